dsp19x2_packed_mult_model: RTL and testbench
============================================

DSP19X2_PACKED_MULT_MODEL -- requirements
Module: dsp19x2_packed_mult_model

Interface
REQ-001 SHALL have parameter COEFF1_0..COEFF1_3, default 10'h000 each: lane-1 A-side coefficients 0..3.
REQ-002 SHALL have parameter COEFF2_0..COEFF2_3, default 10'h000 each: lane-2 A-side coefficients 0..3.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port lreset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port a  input  20  packed A: [19:10] lane 1, [9:0] lane 2.
REQ-006 SHALL have port b  input  18  packed B: [17:9] lane 1, [8:0] lane 2.
REQ-007 SHALL have port feedback  input  3  operand select (REQ-013).
REQ-008 SHALL have port unsigned_a  input  1  1 = A unsigned, 0 = A two's complement.
REQ-009 SHALL have port unsigned_b  input  1  1 = B unsigned, 0 = B two's complement.
REQ-010 SHALL have port in_valid  input  1  qualifies a, b, feedback and unsigned_* this cycle.
REQ-011 SHALL have port z  output  38  packed product: [37:19] lane 1, [18:0] lane 2.
REQ-012 SHALL have ports dly_b  output  18 (registered packed B, same packing as b) and out_valid  output  1 (z qualifier).

Function
REQ-013 Operand select SHALL be: feedback 3'b000 -> lane A from port a; 3'b1xx -> lane A = COEFFn_{feedback[1:0]}, lane 1 uses COEFF1_*, lane 2 uses COEFF2_*; 3'b001..3'b011 -> lane A forced to zero.
REQ-014 Stage 1 (input register) SHALL capture a, b, feedback, unsigned_a, unsigned_b on every clock when in_valid=1. When in_valid=0 it SHALL hold its previous contents.
REQ-015 A stage-1 valid flag SHALL be set to in_valid on every clock.
REQ-016 dly_b SHALL equal the stage-1 B register, i.e. b as captured at the last in_valid=1 edge.
REQ-017 Each lane SHALL compute a 19-bit product of the selected 10-bit A and 9-bit B from stage-1 values.
- Operands are extended to 11/10 bits: zero-extended if unsigned_*=1, sign-extended otherwise.
- The 21-bit product is truncated to 19 bits.
- The result is lossless for every sign combination.
REQ-018 Stage 2 (output register) SHALL load both lane products into z when the stage-1 valid flag is 1, and hold otherwise.
REQ-019 out_valid SHALL equal the stage-1 valid flag delayed one clock.
- Latency from in_valid=1 to the matching out_valid=1 is exactly 2 clocks.
- Throughput is one result per clock.
REQ-020 Lanes SHALL be fully independent: no carry or sign interaction between lane 1 and lane 2 bits of z.
REQ-021 Back-to-back in_valid=1 samples SHALL produce back-to-back results, in order, with no bubbles.
REQ-022 A feedback or unsigned_* change SHALL only affect the samples captured with that value. No retroactive effect on in-flight data.
REQ-023 The block SHALL contain no accumulator, rounding or saturation: plain multiply only.

Reset
REQ-024 While lreset=1 at a clock edge, all stage-1 registers, z, dly_b, out_valid and the valid flags SHALL become 0, overriding in_valid.
REQ-025 lreset asserted mid-stream SHALL discard all in-flight samples.
- out_valid is 0 from the edge after reset until 2 clocks after the first in_valid=1 following deassertion.
REQ-026 The first edge after lreset deasserts SHALL accept input normally. No extra idle cycles are required.

Verification
REQ-027 Signed, feedback=000: lane1 a=10'h200 (-512), b=9'h100 (-256); lane2 a=10'h001, b=9'h1FF (-1). Required result 2 clocks later: z[37:19]=19'd131072, z[18:0]=19'h7FFFF, out_valid=1.
REQ-028 Unsigned extremes: unsigned_a=unsigned_b=1, both lanes a=10'h3FF, b=9'h1FF. Required: each lane 19'd522753.
- Then unsigned_a=1, unsigned_b=0, a=10'h3FF, b=9'h100. Required: each lane -261888 (19'h40100).
REQ-029 Coefficient select: COEFF1_2=10'd5, COEFF2_2=10'd7, feedback=3'b110, a=20'hFFFFF, b lanes=9'd3, signed. Required: lane1=15, lane2=21.
- Then feedback=3'b010: both lanes 0.
REQ-030 Streaming: 8 consecutive in_valid=1 samples with random operands. Required: 8 consecutive out_valid=1 cycles, in order, matching the reference product.
- dly_b tracks b with 1-clock lag.
- An in_valid=0 gap holds dly_b and z, and drops out_valid for the matching cycle.
REQ-031 Reset mid-stream: lreset pulsed for 1 clock while 2 samples are in flight. Required on the next edge: z=0, dly_b=0, out_valid=0.
- No stale result ever appears.
- A sample driven on the edge after deassertion emerges 2 clocks later.

Source files
------------

// File: rtl/dsp19x2_packed_mult_model_if.sv
// Packed dual-lane multiplier bus: operands and controls in, packed products and delayed B out.
interface dsp19x2_packed_mult_model_if;
  logic [19:0] a;
  logic [17:0] b;
  logic [2:0]  feedback;
  logic        unsigned_a;
  logic        unsigned_b;
  logic        in_valid;
  logic [37:0] z;
  logic [17:0] dly_b;
  logic        out_valid;

  modport master (
    output a, b, feedback, unsigned_a, unsigned_b, in_valid,
    input  z, dly_b, out_valid
  );

  modport slave (
    input  a, b, feedback, unsigned_a, unsigned_b, in_valid,
    output z, dly_b, out_valid
  );
endinterface

// File: rtl/dsp19x2_packed_mult_model.sv
// Two independent 10x9 multipliers packed into one 20x18 operand pair, with a
// two-register pipeline (input capture, output product) and coefficient select.
module dsp19x2_packed_mult_model #(
  parameter logic [9:0] COEFF1_0 = 10'h000,
  parameter logic [9:0] COEFF1_1 = 10'h000,
  parameter logic [9:0] COEFF1_2 = 10'h000,
  parameter logic [9:0] COEFF1_3 = 10'h000,
  parameter logic [9:0] COEFF2_0 = 10'h000,
  parameter logic [9:0] COEFF2_1 = 10'h000,
  parameter logic [9:0] COEFF2_2 = 10'h000,
  parameter logic [9:0] COEFF2_3 = 10'h000
) (
  input  logic                           clk,
  input  logic                           lreset,
  dsp19x2_packed_mult_model_if.slave     bus
);

  logic [19:0] a_p1;
  logic [17:0] b_p1;
  logic [2:0]  fb_p1;
  logic        ua_p1;
  logic        ub_p1;
  logic        vld_p1;

  logic [37:0] z_p2;
  logic        vld_p2;

  logic [9:0]  a1_sel;
  logic [9:0]  a2_sel;
  logic [18:0] prod1;
  logic [18:0] prod2;

  // 000 passes the port operand, 1xx picks a lane coefficient, 001..011 forces zero.
  function automatic logic [9:0] sel_a(
    input logic [2:0] fb,
    input logic [9:0] a_port,
    input logic [9:0] c0,
    input logic [9:0] c1,
    input logic [9:0] c2,
    input logic [9:0] c3
  );
    sel_a = '0;
    if (fb == 3'b000) begin
      sel_a = a_port;
    end else if (fb[2]) begin
      case (fb[1:0])
        2'd0:    sel_a = c0;
        2'd1:    sel_a = c1;
        2'd2:    sel_a = c2;
        default: sel_a = c3;
      endcase
    end
  endfunction

  // Only the low 19 product bits are kept, so extending operands to 19 bits is exact.
  function automatic logic [18:0] lane_mult(
    input logic [9:0] a_op,
    input logic [8:0] b_op,
    input logic       ua,
    input logic       ub
  );
    logic signed [18:0] a_ext;
    logic signed [18:0] b_ext;
    a_ext = ua ? {9'b0, a_op} : {{9{a_op[9]}}, a_op};
    b_ext = ub ? {10'b0, b_op} : {{10{b_op[8]}}, b_op};
    lane_mult = a_ext * b_ext;
  endfunction

  // Stage 1: input capture
  always_ff @(posedge clk) begin
    if (lreset) begin
      a_p1   <= '0;
      b_p1   <= '0;
      fb_p1  <= '0;
      ua_p1  <= 1'b0;
      ub_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        a_p1  <= bus.a;
        b_p1  <= bus.b;
        fb_p1 <= bus.feedback;
        ua_p1 <= bus.unsigned_a;
        ub_p1 <= bus.unsigned_b;
      end
    end
  end

  assign a1_sel = sel_a(fb_p1, a_p1[19:10], COEFF1_0, COEFF1_1, COEFF1_2, COEFF1_3);
  assign a2_sel = sel_a(fb_p1, a_p1[9:0],   COEFF2_0, COEFF2_1, COEFF2_2, COEFF2_3);
  assign prod1  = lane_mult(a1_sel, b_p1[17:9], ua_p1, ub_p1);
  assign prod2  = lane_mult(a2_sel, b_p1[8:0],  ua_p1, ub_p1);

  // Stage 2: product register
  always_ff @(posedge clk) begin
    if (lreset) begin
      z_p2   <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        z_p2 <= {prod1, prod2};
      end
    end
  end

  assign bus.z         = z_p2;
  assign bus.dly_b     = b_p1;
  assign bus.out_valid = vld_p2;

endmodule

// File: tb/tb_dsp19x2_packed_mult_model.sv
// Bench for the packed dual-lane multiplier: fixed vectors, random streaming and mid-stream reset.
module tb_dsp19x2_packed_mult_model;

  localparam logic [9:0] C1_0 = 10'h3FF;
  localparam logic [9:0] C1_1 = 10'h0AB;
  localparam logic [9:0] C1_2 = 10'd5;
  localparam logic [9:0] C1_3 = 10'd100;
  localparam logic [9:0] C2_0 = 10'h200;
  localparam logic [9:0] C2_1 = 10'h155;
  localparam logic [9:0] C2_2 = 10'd7;
  localparam logic [9:0] C2_3 = 10'h3F6;

  logic clk;
  logic lreset;
  int   n_cmp;
  int   n_bad;

  dsp19x2_packed_mult_model_if bus ();

  dsp19x2_packed_mult_model #(
    .COEFF1_0(C1_0), .COEFF1_1(C1_1), .COEFF1_2(C1_2), .COEFF1_3(C1_3),
    .COEFF2_0(C2_0), .COEFF2_1(C2_1), .COEFF2_2(C2_2), .COEFF2_3(C2_3)
  ) dut (
    .clk    (clk),
    .lreset (lreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] a;
    logic [17:0] b;
    logic [2:0]  fb;
    logic        ua;
    logic        ub;
    logic [18:0] z1;
    logic [18:0] z2;
  } vec_t;

  vec_t vecs [10];

  // Expected-output model state
  logic        exp_vld;
  logic [37:0] exp_z;
  logic [17:0] exp_dly_b;
  logic        pend_vld;
  logic [37:0] pend_z;

  function automatic int val_a(input logic [9:0] v, input logic u);
    if (!u && v[9]) return int'(v) - 1024;
    return int'(v);
  endfunction

  function automatic int val_b(input logic [8:0] v, input logic u);
    if (!u && v[8]) return int'(v) - 512;
    return int'(v);
  endfunction

  function automatic logic [9:0] coef(input int lane, input logic [1:0] idx);
    logic [9:0] t1 [4];
    logic [9:0] t2 [4];
    t1 = '{C1_0, C1_1, C1_2, C1_3};
    t2 = '{C2_0, C2_1, C2_2, C2_3};
    return (lane == 1) ? t1[idx] : t2[idx];
  endfunction

  function automatic logic [18:0] ref_lane(input int lane, input logic [9:0] a_raw,
                                           input logic [8:0] b_raw, input logic [2:0] fb,
                                           input logic ua, input logic ub);
    int av;
    int p;
    if (fb == 3'b000)   av = val_a(a_raw, ua);
    else if (fb[2])     av = val_a(coef(lane, fb[1:0]), ua);
    else                av = 0;
    p = av * val_b(b_raw, ub);
    return p[18:0];
  endfunction

  function automatic logic [37:0] ref_z(input logic [19:0] a, input logic [17:0] b,
                                        input logic [2:0] fb, input logic ua, input logic ub);
    return {ref_lane(1, a[19:10], b[17:9], fb, ua, ub), ref_lane(2, a[9:0], b[8:0], fb, ua, ub)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive, clock, advance the model and compare every output.
  task automatic cycle(input logic rst_i, input logic v, input logic [19:0] a,
                       input logic [17:0] b, input logic [2:0] fb,
                       input logic ua, input logic ub);
    lreset         = rst_i;
    bus.in_valid   = v;
    bus.a          = a;
    bus.b          = b;
    bus.feedback   = fb;
    bus.unsigned_a = ua;
    bus.unsigned_b = ub;
    @(posedge clk);
    #1;
    if (rst_i) begin
      exp_vld   = 1'b0;
      exp_z     = '0;
      exp_dly_b = '0;
      pend_vld  = 1'b0;
    end else begin
      exp_vld = pend_vld;
      if (pend_vld) exp_z = pend_z;
      if (v) exp_dly_b = b;
      pend_vld = v;
      if (v) pend_z = ref_z(a, b, fb, ua, ub);
    end
    chk("out_valid", 64'(bus.out_valid), 64'(exp_vld));
    chk("z",         64'(bus.z),         64'(exp_z));
    chk("dly_b",     64'(bus.dly_b),     64'(exp_dly_b));
  endtask

  task automatic rand_cycle(input logic rst_i, input logic v);
    logic [2:0] fb;
    fb = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) fb = 3'b000;
    cycle(rst_i, v, 20'($urandom), 18'($urandom), fb,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    exp_vld   = 1'b0;
    exp_z     = '0;
    exp_dly_b = '0;
    pend_vld  = 1'b0;
    pend_z    = '0;

    vecs[0] = '{20'h80001, {9'h100, 9'h1FF}, 3'b000, 1'b0, 1'b0, 19'd131072, 19'h7FFFF};
    vecs[1] = '{20'hFFFFF, {9'h1FF, 9'h1FF}, 3'b000, 1'b1, 1'b1, 19'd522753, 19'd522753};
    vecs[2] = '{20'hFFFFF, {9'h100, 9'h100}, 3'b000, 1'b1, 1'b0, 19'h40100,  19'h40100};
    vecs[3] = '{20'hFFFFF, {9'd3,   9'd3},   3'b110, 1'b0, 1'b0, 19'd15,     19'd21};
    vecs[4] = '{20'hFFFFF, {9'd3,   9'd3},   3'b010, 1'b0, 1'b0, 19'd0,      19'd0};
    vecs[5] = '{20'hFFFFF, {9'd7,   9'h1FF}, 3'b100, 1'b0, 1'b0, 19'h7FFF9,  19'd512};
    vecs[6] = '{20'hFFFFF, {9'd7,   9'h1FF}, 3'b100, 1'b1, 1'b0, 19'd7161,   19'h7FE00};
    vecs[7] = '{{10'd1, 10'h200}, {9'd1, 9'h0FF}, 3'b000, 1'b0, 1'b0, 19'd1, 19'h60200};
    vecs[8] = '{{10'h155, 10'h2AA}, {9'h0AB, 9'h123}, 3'b011, 1'b0, 1'b0, 19'd0, 19'd0};
    vecs[9] = '{20'h12345, {9'd2,   9'd3},   3'b111, 1'b0, 1'b0, 19'd200,    19'h7FFE2};

    // Reset overrides in_valid; everything reads zero.
    cycle(1'b1, 1'b1, 20'hABCDE, 18'h2AAAA, 3'b000, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 20'h12345, 18'h15555, 3'b000, 1'b1, 1'b1);

    // Fixed vectors: one sample, out_valid low after the capture edge, result on the next.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].fb, vecs[i].ua, vecs[i].ub);
      chk("vec_latency_ov", 64'(bus.out_valid), 64'(0));
      cycle(1'b0, 1'b0, 20'($urandom), 18'($urandom), 3'($urandom), 1'b0, 1'b1);
      chk($sformatf("vec%0d_lane1", i), 64'(bus.z[37:19]), 64'(vecs[i].z1));
      chk($sformatf("vec%0d_lane2", i), 64'(bus.z[18:0]),  64'(vecs[i].z2));
      chk($sformatf("vec%0d_ov", i),    64'(bus.out_valid), 64'(1));
    end

    // Eight back-to-back samples, then a gap that must hold z and dly_b.
    for (int i = 0; i < 8; i++) rand_cycle(1'b0, 1'b1);
    rand_cycle(1'b0, 1'b0);
    rand_cycle(1'b0, 1'b0);
    chk("gap_ov", 64'(bus.out_valid), 64'(0));

    // Reset with two samples in flight, then a sample on the first free edge.
    rand_cycle(1'b0, 1'b1);
    rand_cycle(1'b0, 1'b1);
    rand_cycle(1'b1, 1'b1);
    chk("rst_z",     64'(bus.z),         64'(0));
    chk("rst_dly_b", 64'(bus.dly_b),     64'(0));
    chk("rst_ov",    64'(bus.out_valid), 64'(0));
    cycle(1'b0, 1'b1, {10'd3, 10'h3FE}, {9'd5, 9'd6}, 3'b000, 1'b0, 1'b0);
    chk("post_rst_no_stale", 64'(bus.out_valid), 64'(0));
    rand_cycle(1'b0, 1'b0);
    chk("post_rst_ov",   64'(bus.out_valid), 64'(1));
    chk("post_rst_z",    64'(bus.z), 64'({19'd15, 19'h7FFF4}));

    // Random traffic with random valid gaps and occasional reset.
    for (int i = 0; i < 300; i++) begin
      rand_cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
